// File: rtl/noc_pkg.sv
// noc_pkg: flit format constants and demux state encoding shared by router ingress and NI receive side.
package noc_pkg;
   localparam int FLIT_W = 8;
   localparam int MAX_PAYLOAD = 4;
   localparam logic [5:0] HDR_TAG = 6'b101111;
   localparam logic [FLIT_W-1:0] TAIL_FLIT = 8'hFF;
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ROUTE = 2'd1, ST_DROP = 2'd2} demux_state_e;
endpackage

// File: rtl/noc_flit_demux_if.sv
// noc_flit_demux_if: flit ingress handshake and four-port egress bundle of the demux.
interface noc_flit_demux_if;
   import noc_pkg::*;
   logic [FLIT_W-1:0] in_flit;
   logic              in_valid;
   logic              in_ready;
   logic [FLIT_W-1:0] out_flit;
   logic [3:0]        out_valid;
   logic [3:0]        out_ready;
   logic              busy;
   logic              hdr_err;
   modport master (output in_flit, in_valid, out_ready, input in_ready, out_flit, out_valid, busy, hdr_err);
   modport slave  (input in_flit, in_valid, out_ready, output in_ready, out_flit, out_valid, busy, hdr_err);
endinterface

// File: rtl/flit_fifo.sv
// flit_fifo: first-word-fall-through FIFO; DEPTH must be a power of two and at least 2.
module flit_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] din_i,
   output logic [W-1:0] dout_o,
   output logic         full_o,
   output logic         empty_o
);
   localparam int AW = $clog2(DEPTH);
   typedef logic [AW:0] cnt_t;
   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   cnt_t          cnt_q;
   assign dout_o  = mem_q[rd_q];
   assign full_o  = cnt_q == cnt_t'(DEPTH);
   assign empty_o = cnt_q == '0;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_i) wr_q <= wr_q + 1'b1;
         if (pop_i) rd_q <= rd_q + 1'b1;
         cnt_q <= cnt_q + cnt_t'(push_i) - cnt_t'(pop_i);
      end
   always_ff @(posedge clk)
      if (push_i) mem_q[wr_q] <= din_i;
endmodule

// File: rtl/noc_flit_demux.sv
// noc_flit_demux: ingress FIFO plus wormhole steering of each packet to one of four ports.
// Define PKT_COUNT_EN to add per-port delivered-packet counters on pkt_count.
module noc_flit_demux import noc_pkg::*; #(
   parameter int FIFO_DEPTH = 4,
   parameter int NUM_PORTS  = 4
) (
   input logic clk,
   input logic rst_n,
   noc_flit_demux_if.slave bus
`ifdef PKT_COUNT_EN
   ,
   output logic [31:0] pkt_count
`endif
);
   localparam logic [1:0] IDLE  = ST_IDLE;
   localparam logic [1:0] ROUTE = ST_ROUTE;
   localparam logic [1:0] DROP  = ST_DROP;
   logic [FLIT_W-1:0]    head;
   logic                 empty, full, push, pop, tail;
   logic [1:0]           state_q, state_d, sel_q, sel_d;
   logic [2:0]           cnt_q, cnt_d;
   logic [NUM_PORTS-1:0] hot;
   flit_fifo #(.W(FLIT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .pop_i   (pop),
      .din_i   (bus.in_flit),
      .dout_o  (head),
      .full_o  (full),
      .empty_o (empty)
   );
   assign push          = bus.in_valid && !full;
   // 8'hFF directly after the header is payload; the count forces a tail after four payloads
   assign tail          = (cnt_q != 3'd0 && head == TAIL_FLIT) || cnt_q == 3'(MAX_PAYLOAD);
   assign bus.in_ready  = !full;
   assign bus.out_flit  = empty ? '0 : head;
   assign bus.out_valid = hot;
   assign bus.busy      = state_q == ROUTE;
   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      cnt_d       = cnt_q;
      pop         = 1'b0;
      hot         = '0;
      bus.hdr_err = 1'b0;
      if (state_q == IDLE && !empty) begin
         cnt_d = '0;
         sel_d = head[1:0];
         if (head[7:2] == HDR_TAG) begin
            hot[head[1:0]] = 1'b1;
            pop            = bus.out_ready[head[1:0]];
            state_d        = pop ? ROUTE : IDLE;
         end else begin
            pop         = 1'b1;
            bus.hdr_err = 1'b1;
            state_d     = DROP;
         end
      end else if (state_q != IDLE && !empty) begin
         hot[sel_q] = state_q == ROUTE;
         pop        = state_q == DROP || bus.out_ready[sel_q];
         state_d    = pop && tail ? IDLE : state_q;
         cnt_d      = pop && !tail && cnt_q < 3'(MAX_PAYLOAD) ? cnt_q + 3'd1 : cnt_q;
      end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         sel_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
      end
`ifdef PKT_COUNT_EN
   logic [31:0] pkt_q;
   assign pkt_count = pkt_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) pkt_q <= '0;
      else if (state_q == ROUTE && pop && tail) pkt_q[8*sel_q +: 8] <= pkt_q[8*sel_q +: 8] + 8'd1;
`endif
endmodule

// File: tb/tb_noc_flit_demux.sv
// tb_noc_flit_demux: directed scenarios for the flit demux with hand-computed expectations.
module tb_noc_flit_demux;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;
   noc_flit_demux_if bus();
`ifdef PKT_COUNT_EN
   logic [31:0] pkt_count;
`endif
   noc_flit_demux dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef PKT_COUNT_EN
      ,
      .pkt_count (pkt_count)
`endif
   );
   always #5 clk = ~clk;

   task automatic drive(input logic [7:0] f);
      bus.in_flit  = f;
      bus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_cycle();
      bus.in_flit  = 8'h00;
      bus.in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_chk++;
      if ({bus.in_ready, bus.out_valid, bus.out_flit, bus.busy, bus.hdr_err} !== {1'b1, 4'h0, 8'h00, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_state: got rdy/vld/flit/busy/err=%b want %b", {bus.in_ready, bus.out_valid, bus.out_flit, bus.busy, bus.hdr_err}, {1'b1, 4'h0, 8'h00, 1'b0, 1'b0});
      end
`ifdef PKT_COUNT_EN
      n_chk++;
      if (pkt_count !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_count: got %h want 00000000", pkt_count);
      end
`endif
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [7:0] pk [6] = '{8'hBE, 8'h11, 8'h22, 8'h33, 8'h44, 8'hFF};
      for (int i = 0; i < 6; i++) begin
         drive(pk[i]);
         n_chk++;
         if ({bus.out_valid, bus.out_flit, bus.busy} !== {4'b0100, pk[i], i != 0}) begin
            n_fail++;
            $display("FAIL basic_flit%0d: got vld=%b flit=%h busy=%b want vld=0100 flit=%h busy=%b", i, bus.out_valid, bus.out_flit, bus.busy, pk[i], i != 0);
         end
      end
      idle_cycle();
      n_chk++;
      if ({bus.busy, bus.out_valid, bus.out_flit, bus.in_ready} !== {1'b0, 4'h0, 8'h00, 1'b1}) begin
         n_fail++;
         $display("FAIL basic_after_tail: got busy/vld/flit/rdy=%b want %b", {bus.busy, bus.out_valid, bus.out_flit, bus.in_ready}, {1'b0, 4'h0, 8'h00, 1'b1});
      end
   endtask

   task automatic test_short();
      logic [7:0] pk [4] = '{8'hBD, 8'hFF, 8'h12, 8'hFF};
      for (int i = 0; i < 4; i++) begin
         drive(pk[i]);
         n_chk++;
         if ({bus.out_valid, bus.out_flit, bus.busy} !== {4'b0010, pk[i], i != 0}) begin
            n_fail++;
            $display("FAIL short_flit%0d: got vld=%b flit=%h busy=%b want vld=0010 flit=%h busy=%b", i, bus.out_valid, bus.out_flit, bus.busy, pk[i], i != 0);
         end
      end
      idle_cycle();
      n_chk++;
      if ({bus.busy, bus.out_valid} !== {1'b0, 4'h0}) begin
         n_fail++;
         $display("FAIL short_after_tail: got busy=%b vld=%b want busy=0 vld=0000", bus.busy, bus.out_valid);
      end
   endtask

   task automatic test_four_payload();
      logic [7:0] pk [18] = '{8'hBC, 8'h01, 8'h02, 8'h03, 8'h04, 8'hFF, 8'hBF, 8'h55, 8'hFF,
                              8'hBD, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h5A, 8'hBE, 8'h66, 8'hFF};
      logic [3:0] ev [18] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h8, 4'h8, 4'h8,
                              4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h4, 4'h4, 4'h4};
      logic eb;
      for (int i = 0; i < 18; i++) begin
         drive(pk[i]);
         eb = !(i == 0 || i == 6 || i == 9 || i == 15);
         n_chk++;
         if ({bus.out_valid, bus.out_flit, bus.busy} !== {ev[i], pk[i], eb}) begin
            n_fail++;
            $display("FAIL four_flit%0d: got vld=%b flit=%h busy=%b want vld=%b flit=%h busy=%b", i, bus.out_valid, bus.out_flit, bus.busy, ev[i], pk[i], eb);
         end
      end
      idle_cycle();
      n_chk++;
      if ({bus.busy, bus.out_valid} !== {1'b0, 4'h0}) begin
         n_fail++;
         $display("FAIL four_after_tail: got busy=%b vld=%b want busy=0 vld=0000", bus.busy, bus.out_valid);
      end
   endtask

   task automatic test_back_pressure();
      logic [7:0] pk [5] = '{8'hBC, 8'hA1, 8'hA2, 8'hA3, 8'hFF};
      logic [7:0] rx [5] = '{default: 8'h00};
      int sent = 0;
      int got = 0;
      logic acc, take;
      bus.out_ready = 4'hE;
      for (int c = 0; c < 40 && got < 5; c++) begin
         if (c == 8) bus.out_ready = 4'hF;
         bus.in_valid = sent < 5;
         bus.in_flit  = sent < 5 ? pk[sent] : 8'h00;
         if (c >= 1 && c < 8) begin
            n_chk++;
            if ({bus.out_valid, bus.out_flit} !== {4'b0001, 8'hBC}) begin
               n_fail++;
               $display("FAIL bp_hold_c%0d: got vld=%b flit=%h want vld=0001 flit=bc", c, bus.out_valid, bus.out_flit);
            end
         end
         if (c == 6) begin
            n_chk++;
            if (bus.in_ready !== 1'b0 || sent != 4) begin
               n_fail++;
               $display("FAIL bp_full: got in_ready=%b accepted=%0d want in_ready=0 accepted=4", bus.in_ready, sent);
            end
         end
         acc  = bus.in_valid && bus.in_ready;
         take = bus.out_valid[0] && bus.out_ready[0];
         if (take) rx[got] = bus.out_flit;
         @(posedge clk);
         @(negedge clk);
         if (acc) sent++;
         if (take) got++;
      end
      bus.in_valid = 1'b0;
      n_chk++;
      if (got != 5) begin
         n_fail++;
         $display("FAIL bp_count: got %0d flits want 5", got);
      end
      for (int k = 0; k < 5; k++) begin
         n_chk++;
         if (rx[k] !== pk[k]) begin
            n_fail++;
            $display("FAIL bp_order%0d: got %h want %h", k, rx[k], pk[k]);
         end
      end
      n_chk++;
      if ({bus.busy, bus.out_valid} !== {1'b0, 4'h0}) begin
         n_fail++;
         $display("FAIL bp_drained: got busy=%b vld=%b want busy=0 vld=0000", bus.busy, bus.out_valid);
      end
   endtask

   task automatic test_bad_header();
      logic [7:0] pk [6] = '{8'h40, 8'h55, 8'hFF, 8'hBC, 8'h77, 8'hFF};
      logic [3:0] ev [6] = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h1};
      for (int i = 0; i < 6; i++) begin
         drive(pk[i]);
         n_chk++;
         if ({bus.out_valid, bus.out_flit, bus.hdr_err} !== {ev[i], pk[i], i == 0}) begin
            n_fail++;
            $display("FAIL bad_hdr%0d: got vld=%b flit=%h err=%b want vld=%b flit=%h err=%b", i, bus.out_valid, bus.out_flit, bus.hdr_err, ev[i], pk[i], i == 0);
         end
      end
      idle_cycle();
      n_chk++;
      if ({bus.busy, bus.out_valid, bus.hdr_err} !== {1'b0, 4'h0, 1'b0}) begin
         n_fail++;
         $display("FAIL bad_hdr_after: got busy=%b vld=%b err=%b want 0 0000 0", bus.busy, bus.out_valid, bus.hdr_err);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] pk [3] = '{8'hBF, 8'h21, 8'h22};
      logic [7:0] pn [3] = '{8'hBE, 8'h31, 8'hFF};
      for (int i = 0; i < 3; i++) drive(pk[i]);
      n_chk++;
      if ({bus.busy, bus.out_valid, bus.out_flit} !== {1'b1, 4'b1000, 8'h22}) begin
         n_fail++;
         $display("FAIL rst_pre: got busy=%b vld=%b flit=%h want 1 1000 22", bus.busy, bus.out_valid, bus.out_flit);
      end
      drive(8'h23);
      bus.in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      n_chk++;
      if ({bus.out_valid, bus.busy, bus.in_ready, bus.out_flit} !== {4'h0, 1'b0, 1'b1, 8'h00}) begin
         n_fail++;
         $display("FAIL rst_mid: got vld/busy/rdy/flit=%b want %b", {bus.out_valid, bus.busy, bus.in_ready, bus.out_flit}, {4'h0, 1'b0, 1'b1, 8'h00});
      end
`ifdef PKT_COUNT_EN
      n_chk++;
      if (pkt_count !== 32'h0) begin
         n_fail++;
         $display("FAIL rst_mid_count: got %h want 00000000", pkt_count);
      end
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         drive(pn[i]);
         n_chk++;
         if ({bus.out_valid, bus.out_flit} !== {4'b0100, pn[i]}) begin
            n_fail++;
            $display("FAIL rst_next%0d: got vld=%b flit=%h want vld=0100 flit=%h", i, bus.out_valid, bus.out_flit, pn[i]);
         end
      end
      idle_cycle();
      n_chk++;
      if ({bus.busy, bus.out_valid} !== {1'b0, 4'h0}) begin
         n_fail++;
         $display("FAIL rst_next_done: got busy=%b vld=%b want busy=0 vld=0000", bus.busy, bus.out_valid);
      end
`ifdef PKT_COUNT_EN
      n_chk++;
      if (pkt_count !== 32'h0001_0000) begin
         n_fail++;
         $display("FAIL rst_next_count: got %h want 00010000", pkt_count);
      end
`endif
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_flit   = 8'h00;
      bus.out_ready = 4'hF;
      test_reset();
      test_basic();
      test_short();
      test_four_payload();
      test_back_pressure();
      test_bad_header();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/noc_flit_demux.md
Name: noc_flit_demux

Overview:
- Router ingress stage directly downstream of the network interface's flit transmitter.
- Accepts an 8-bit flit stream through a valid/ready handshake and buffers it in a small FIFO.
- Decodes the header flit, steers the whole packet (wormhole) to one of four output ports selected by the 2-bit destination, and releases the path after the tail flit.
- Packet format: header = {6'b101111, dest[1:0]}; 1..4 payload flits; tail = 8'hFF.

Parameters:
- FIFO_DEPTH, 4, ingress FIFO depth in flits; must be a power of two, minimum 2.
- NUM_PORTS, 4, number of output ports; fixed at 4 because dest is 2 bits.

Ports:
- clk  in  1  Single clock; all state changes on its rising edge.
- rst_n  in  1  Asynchronous, active-low reset.
- in_flit  in  8  Incoming flit.
- in_valid  in  1  in_flit is valid.
- in_ready  out  1  Demux can accept a flit (FIFO not full).
- out_flit  out  8  Flit broadcast to all ports; only the selected port's valid is asserted.
- out_valid  out  4  One-hot per-port valid.
- out_ready  in  4  Per-port ready.
- busy  out  1  A packet path is currently locked.
- hdr_err  out  1  One-cycle pulse when a malformed header is dropped.

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_flit=0, busy=0, hdr_err=0; FIFO empty, payload count 0, state IDLE.
- Ingress: a flit is written when in_valid && in_ready. in_ready = !full, registered from FIFO occupancy.
- Ingress with simultaneous push and pop on a full FIFO: the push is refused, because in_ready was already 0.
- FIFO: first-word-fall-through, with pointer wrap at FIFO_DEPTH.
- Minimum latency: 1 cycle from an accepted flit to out_valid, when the FIFO was empty and the path is free.
- Output: out_flit is driven from the FIFO head. A pop occurs when out_valid[sel] && out_ready[sel]. Other ports' ready inputs are ignored.
- State machine:
  - IDLE: waits for a FIFO head flit.
    - If head[7:2]==6'b101111: latch sel=head[1:0], forward the header on port sel, clear payload count, go to ROUTE once the header pops.
    - Otherwise: pop the flit without forwarding, pulse hdr_err, go to DROP.
  - ROUTE: forward each head flit on port sel.
    - A flit is the tail when (count>=1 && flit==8'hFF) or count==4.
    - Popping a non-tail flit increments count (3-bit, saturates at 4).
    - Popping the tail returns the state to IDLE.
  - DROP: pop every flit at one per cycle with out_valid=0, applying the same tail rule. The tail pop returns the state to IDLE.
- Payload rule: 8'hFF as the first payload flit is payload, not tail; this matches the transmitter, which always sends flit_a.
- busy = 1 in ROUTE, 0 otherwise.
- out_ready deasserted mid-packet: hold out_flit and out_valid stable. Never drop or reorder flits.
- An empty FIFO in ROUTE gives out_valid=0 while the path stays locked; other destinations cannot intervene.
- Reset mid-packet: immediately clear the FIFO, the state and all outputs. A partial packet is discarded and not completed.

Optional Feature:
- Macro PKT_COUNT_EN.
- Defined:
  - Adds output port pkt_count, 32 bits, made of four 8-bit counters; byte i counts packets whose tail popped on port i.
  - Counters wrap from 255 to 0 and reset to 0.
  - Dropped packets are not counted.
- Undefined: no port, no counters; behaviour is otherwise identical.

Decomposition:
- Package noc_pkg:
  - HDR_TAG = 6'b101111, TAIL_FLIT = 8'hFF, MAX_PAYLOAD = 4, FLIT_W = 8.
  - Demux state enum {IDLE, ROUTE, DROP}, shareable with the NI receive side.
- Sub-module flit_fifo: parameterised by width and depth, with push/pop/full/empty.
- Routing FSM and output steering stay in noc_flit_demux.

Test Plan:
- Basic packet: push 8'hBE, 8'h11, 8'h22, 8'h33, 8'h44, 8'hFF with out_ready=4'hF. Expected: all six flits appear on port 2 only (out_valid=4'b0100) in order, busy drops after the 8'hFF pops, and the FIFO is empty.
- Short packet: push 8'hBD, 8'hFF, 8'h12, 8'hFF. Expected: 8'hFF is treated as payload and 8'h12 as payload, the second 8'hFF is the tail, and 4 flits appear on port 1.
- Four-payload tail: push 8'hBC, 8'h01, 8'h02, 8'h03, 8'h04, 8'hFF. Expected: the tail is recognised at count 4, and the next header 8'hBF then routes to port 3.
- Back-pressure: hold out_ready[0]=0 mid-packet while pushing continuously. Expected: out_flit is stable, in_ready=0 after FIFO_DEPTH accepted flits, and no flit is lost or duplicated after release.
- Bad header: push 8'h40, 8'h55, 8'hFF, then a valid packet to port 0. Expected: hdr_err pulses once, nothing is forwarded for the bad packet, and the valid packet is delivered intact.
- Reset mid-packet: assert rst_n=0 after the header and 2 payload flits. Expected: out_valid=0, busy=0, in_ready=1 immediately; the next packet routes correctly. With PKT_COUNT_EN, the counters read 0.
